// File: rtl/servo_pkg.sv
// Shared servo constants, direction codes and decoder FSM states.
// Imported by the generator and the receive-side decoder.
package servo_pkg;

    localparam logic [29:0] POS        = 30'd10_0000;
    localparam logic [29:0] NEG        = 30'd20_0000;
    localparam logic [29:0] STOP       = 30'd15_0000;
    localparam logic [29:0] WAVELENGTH = 30'd200_0000;
    localparam logic [29:0] TOL        = 30'd5000;
    localparam logic [29:0] TIMEOUT    = 30'd400_0000;

    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;
    localparam logic [1:0] DIR_STOP = 2'b00;

    localparam logic [1:0] S_WAIT_RISE = 2'd0;
    localparam logic [1:0] S_HIGH      = 2'd1;
    localparam logic [1:0] S_LOW       = 2'd2;

    function automatic logic near(
        input logic [29:0] a,
        input logic [29:0] b,
        input logic [29:0] tol
    );
        logic [29:0] d;
        d = (a >= b) ? a - b : b - a;
        return d <= tol;
    endfunction

    function automatic logic [29:0] sat_inc(input logic [29:0] v);
        return (&v) ? v : v + 30'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with registered rise/fall strobes.
// Strobes stay quiet until every stage holds a real sample after reset.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;
    logic [2:0] fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            fill <= 3'b000;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            fill <= {fill[1:0], 1'b1};
        end
    end

    // A line already high at reset release must not look like a rise.
    assign level = s2;
    assign rise  = fill[2] & s2 & ~s3;
    assign fall  = fill[2] & ~s2 & s3;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM receiver: measures high time and period, decodes direction,
// and flags loss of signal.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter logic [29:0] POS        = servo_pkg::POS,
    parameter logic [29:0] NEG        = servo_pkg::NEG,
    parameter logic [29:0] STOP       = servo_pkg::STOP,
    parameter logic [29:0] WAVELENGTH = servo_pkg::WAVELENGTH,
    parameter logic [29:0] TOL        = servo_pkg::TOL,
    parameter logic [29:0] TIMEOUT    = servo_pkg::TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_in,
    output logic [29:0] pulse_width,
    output logic        width_valid,
    output logic [1:0]  dir,
    output logic        width_err,
    output logic [29:0] period,
    output logic        period_ok,
    output logic        sig_lost
);

    logic        level;
    logic        rise;
    logic        fall;
    logic        any_edge;
    logic        timeout;
    logic [1:0]  state;
    logic [29:0] hi_cnt;
    logic [29:0] per_cnt;
    logic [29:0] idle_cnt;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign any_edge = rise | fall;
    assign timeout  = !any_edge && (idle_cnt >= TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_WAIT_RISE;
            hi_cnt      <= '0;
            per_cnt     <= '0;
            idle_cnt    <= '0;
            pulse_width <= '0;
            width_valid <= 1'b0;
            dir         <= DIR_STOP;
            width_err   <= 1'b0;
            period      <= '0;
            period_ok   <= 1'b0;
            sig_lost    <= 1'b1;
        end else begin
            width_valid <= 1'b0;
            idle_cnt    <= any_edge ? '0 : sat_inc(idle_cnt);

            if (timeout) begin
                sig_lost  <= 1'b1;
                dir       <= DIR_STOP;
                period_ok <= 1'b0;
                state     <= S_WAIT_RISE;
            end else begin
                unique case (state)
                    S_WAIT_RISE: begin
                        if (rise) begin
                            hi_cnt  <= 30'd1;
                            per_cnt <= 30'd1;
                            state   <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        per_cnt <= sat_inc(per_cnt);
                        if (fall) begin
                            pulse_width <= hi_cnt;
                            width_valid <= 1'b1;
                            state       <= S_LOW;
                            if (near(hi_cnt, POS, TOL)) begin
                                dir       <= DIR_CCW;
                                width_err <= 1'b0;
                                sig_lost  <= 1'b0;
                            end else if (near(hi_cnt, NEG, TOL)) begin
                                dir       <= DIR_CW;
                                width_err <= 1'b0;
                                sig_lost  <= 1'b0;
                            end else if (near(hi_cnt, STOP, TOL)) begin
                                dir       <= DIR_STOP;
                                width_err <= 1'b0;
                                sig_lost  <= 1'b0;
                            end else begin
                                width_err <= 1'b1;
                            end
                        end else if (level) begin
                            hi_cnt <= sat_inc(hi_cnt);
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            period    <= per_cnt;
                            period_ok <= near(per_cnt, WAVELENGTH + 30'd1, TOL);
                            per_cnt   <= 30'd1;
                            hi_cnt    <= 30'd1;
                            state     <= S_HIGH;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                        end
                    end
                    default: state <= S_WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder with scaled-down timing constants.
// Expected decode results are queued per pulse and checked on width_valid.
module tb_servo_pwm_decoder;

    localparam int C_POS  = 40;
    localparam int C_NEG  = 80;
    localparam int C_STOP = 60;
    localparam int C_WL   = 199;
    localparam int C_TOL  = 4;
    localparam int C_TO   = 400;

    typedef struct {
        int         w;
        logic [1:0] d;
        logic       e;
        int         p;
        logic       pok;
        logic       lost;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [29:0] pulse_width;
    logic        width_valid;
    logic [1:0]  dir;
    logic        width_err;
    logic [29:0] period;
    logic        period_ok;
    logic        sig_lost;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_push = 0;
    exp_t q[$];

    int         m_period;
    int         m_prev_len;
    logic       m_pok;
    logic       m_lost;
    logic       m_wait;
    logic       m_err;
    logic [1:0] m_dir;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .POS        (30'(C_POS)),
        .NEG        (30'(C_NEG)),
        .STOP       (30'(C_STOP)),
        .WAVELENGTH (30'(C_WL)),
        .TOL        (30'(C_TOL)),
        .TIMEOUT    (30'(C_TO))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .pulse_width (pulse_width),
        .width_valid (width_valid),
        .dir         (dir),
        .width_err   (width_err),
        .period      (period),
        .period_ok   (period_ok),
        .sig_lost    (sig_lost)
    );

    function automatic logic close(int a, int b);
        return ((a > b) ? a - b : b - a) <= C_TOL;
    endfunction

    task automatic model_reset();
        m_period   = 0;
        m_prev_len = 0;
        m_pok      = 1'b0;
        m_lost     = 1'b1;
        m_wait     = 1'b1;
        m_err      = 1'b0;
        m_dir      = 2'b00;
    endtask

    task automatic model_loss();
        m_lost = 1'b1;
        m_dir  = 2'b00;
        m_pok  = 1'b0;
        m_wait = 1'b1;
    endtask

    // One pulse: h cycles high then l cycles low, with model update.
    task automatic pulse(int h, int l);
        exp_t x;
        logic rose;
        rose   = m_wait;
        pwm_in = 1'b1;
        if (!m_wait) begin
            m_period = m_prev_len;
            m_pok    = close(m_prev_len, C_WL + 1);
        end
        m_wait = 1'b0;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        if (h > C_TO + 1) begin
            model_loss();
        end else begin
            if (close(h, C_POS)) begin
                m_dir = 2'b10; m_err = 1'b0; m_lost = 1'b0;
            end else if (close(h, C_NEG)) begin
                m_dir = 2'b01; m_err = 1'b0; m_lost = 1'b0;
            end else if (close(h, C_STOP)) begin
                m_dir = 2'b00; m_err = 1'b0; m_lost = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            x = '{h, m_dir, m_err, m_period, m_pok, m_lost};
            q.push_back(x);
            n_push++;
        end
        if (rose) begin end
        repeat (l) @(negedge clk);
        if (l > C_TO + 1) model_loss();
        m_prev_len = h + l;
    endtask

    task automatic check_reset_vals(string name);
        n_cmp++;
        if ({pulse_width, width_valid, dir, width_err, period, period_ok, sig_lost}
            !== {30'd0, 1'b0, 2'b00, 1'b0, 30'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL %s: got w=%0d v=%b d=%b e=%b p=%0d pok=%b lost=%b, need all zero and lost=1",
                     name, pulse_width, width_valid, dir, width_err, period, period_ok, sig_lost);
        end
    endtask

    task automatic check_lost(string name);
        n_cmp++;
        if ({sig_lost, dir, period_ok} !== {1'b1, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL %s: got lost=%b dir=%b pok=%b, need lost=1 dir=00 pok=0",
                     name, sig_lost, dir, period_ok);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && width_valid) begin
            n_valid++;
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: got width=%0d dir=%b, need no strobe",
                         pulse_width, dir);
            end else begin
                e = q.pop_front();
                if (pulse_width !== 30'(e.w) || dir !== e.d || width_err !== e.e ||
                    period !== 30'(e.p) || period_ok !== e.pok || sig_lost !== e.lost) begin
                    n_bad++;
                    $display("FAIL decode: got w=%0d d=%b e=%b p=%0d pok=%b lost=%b, need w=%0d d=%b e=%b p=%0d pok=%b lost=%b",
                             pulse_width, dir, width_err, period, period_ok, sig_lost,
                             e.w, e.d, e.e, e.p, e.pok, e.lost);
                end
            end
        end
    end

    initial begin
        int cls;
        int h;
        int l;
        rst    = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Nominal POS pulses; the second one carries the first period.
        repeat (3) pulse(C_POS, C_WL + 1 - C_POS);
        // NEG then switch to STOP.
        repeat (2) pulse(C_NEG, C_WL + 1 - C_NEG);
        repeat (2) pulse(C_STOP, C_WL + 1 - C_STOP);
        // Tolerance edges, inclusive accept and first reject.
        pulse(C_POS + C_TOL, 150);
        pulse(C_POS + C_TOL + 1, 150);
        pulse(C_POS - C_TOL, 160);
        pulse(C_POS - C_TOL - 1, 160);
        pulse(1, 198);
        pulse(C_NEG, 120);

        // Stuck low, then recovery with a STOP pulse.
        pulse(C_POS, C_TO + 60);
        check_lost("lost_low");
        pulse(C_STOP, 140);
        pulse(C_STOP, 140);

        // Stuck high: no strobe, then recovery with POS.
        pulse(C_TO + 60, 100);
        check_lost("lost_high");
        pulse(C_POS, 160);
        pulse(C_POS, 160);

        // Reset in the middle of a high pulse.
        pwm_in = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("reset_mid_pulse");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        pulse(C_POS, 160);
        pulse(C_NEG, 120);

        // Randomized pulses around each class, some outside tolerance.
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 2);
            h   = (cls == 0) ? C_POS : (cls == 1) ? C_NEG : C_STOP;
            h   = h + $urandom_range(0, 12) - 6;
            l   = C_WL + 1 - h + $urandom_range(0, 10) - 5;
            pulse(h, l);
        end

        repeat (20) @(negedge clk);
        n_cmp++;
        if (q.size() != 0 || n_valid != n_push) begin
            n_bad++;
            $display("FAIL drain: got strobes=%0d pending=%0d, need strobes=%0d pending=0",
                     n_valid, q.size(), n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
